keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner for the GPIO subsystem. It continuously scans a ROWS×COLS active-low key matrix with a programmable scan rate and frame-level debounce. It exposes a debounced one-hot-per-key bitmap plus a FIFO of press/release events with a valid/ready handshake, so software need not poll. It is the multi-size, debounced, event-capable successor to the fixed 4×4 keypad block.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/keypad_event_fifo.sv | 66 ++++++
 rtl/keypad_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner and its event FIFO.
package keypad_pkg;

    // Event encoding: MSB is the press/release flag, lower bits the key index.
    localparam logic PRESS   = 1'b1;
    localparam logic RELEASE = 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } emit_state_t;

    // Width of one event word: key index plus the press flag.
    function automatic int ev_w(input int rows, input int cols);
        return $clog2(rows * cols) + 1;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous FIFO for GPIO event words. Pushes while full are ignored
// unless a pop happens on the same edge; the caller detects drops itself.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CNTW-1:0] r_count;
    logic            w_pop;
    logic            w_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_pop);
    // Head word is forced to zero while empty so the output is defined after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    // Storage array; no reset needed since reads are masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column sequencing, frame-level debounce, debounced
// key bitmap and an ordered press/release event queue.
//
// Emitter states:
//   state | meaning
//   IDLE  | waiting for a debounced commit
//   WALK  | stepping idx 0..N-1, pushing an event for each changed key
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int CLK_DIV  = 50,
    parameter int DEBOUNCE = 3,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ROWS-1:0]               keypad_row,
    output logic [COLS-1:0]               keypad_col,
    output logic [ROWS*COLS-1:0]          keypad,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [ev_w(ROWS, COLS)-1:0]   event_data,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int N    = ROWS * COLS;
    localparam int IW   = $clog2(N);
    localparam int EW   = ev_w(ROWS, COLS);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int CW   = $clog2(COLS);
    localparam int SW   = $clog2(DEBOUNCE + 1);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DW-1:0]   r_div;
    logic [CW-1:0]   r_col;
    logic [N-1:0]    r_raw;
    logic [N-1:0]    r_prev;
    logic [SW-1:0]   r_stable;
    logic            r_frame_done;
    logic [N-1:0]    r_keypad;
    logic [N-1:0]    r_changed;
    logic [IW-1:0]   r_idx;
    logic            r_overflow;
    emit_state_t     r_state;
    emit_state_t     w_state_next;

    logic            w_tick;
    logic            w_frame_end;
    logic [N-1:0]    w_raw_next;
    logic            w_commit;
    logic            w_push;
    logic [EW-1:0]   w_push_data;
    logic            w_pop;
    logic            w_drop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CNTW-1:0] w_fifo_count;

    assign w_tick      = (r_div == DW'(CLK_DIV - 1));
    assign w_frame_end = w_tick & (r_col == CW'(COLS - 1));

    // Divider: one tick per column slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Column sequencer advances on each tick, wrapping after the last column.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col <= '0;
        end else if (w_tick) begin
            if (r_col == CW'(COLS - 1)) begin
                r_col <= '0;
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Drive only the current column low.
    always_comb begin
        keypad_col = ~(COLS'(1) << r_col);
    end

    // Raw matrix with the current column's sense lines merged in on a tick.
    always_comb begin
        w_raw_next = r_raw;
        for (int c = 0; c < COLS; c++) begin
            if (w_tick && (r_col == CW'(c))) begin
                w_raw_next[c*ROWS +: ROWS] = ~keypad_row;
            end
        end
    end

    // Frame capture and debounce counter; compares the completed frame with the last one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_raw        <= '0;
            r_prev       <= '0;
            r_stable     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_raw        <= w_raw_next;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_prev <= w_raw_next;
                if (w_raw_next == r_prev) begin
                    if (r_stable != SW'(DEBOUNCE)) begin
                        r_stable <= r_stable + SW'(1);
                    end
                end else begin
                    r_stable <= '0;
                end
            end
        end
    end

    // Commit is evaluated once, on the cycle after a frame ends, so a half-updated
    // raw matrix from the next frame can never be committed.
    assign w_commit = r_frame_done & (r_stable == SW'(DEBOUNCE)) & (r_raw != r_keypad);

    // Debounced bitmap and the set of keys the emitter has to report.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_keypad  <= '0;
            r_changed <= '0;
        end else if (w_commit) begin
            r_keypad  <= r_raw;
            r_changed <= r_raw ^ r_keypad;
        end
    end

    assign keypad = r_keypad;

    // Emitter state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Emitter next-state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_commit) w_state_next = WALK;
            WALK: if (r_idx == IW'(N - 1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Emitter outputs: one candidate event per walked index.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        if (r_state == WALK) begin
            w_push      = r_changed[r_idx];
            w_push_data = {(r_keypad[r_idx] ? PRESS : RELEASE), r_idx};
        end
    end

    // Walk index: parked at zero in IDLE so each walk starts at key 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (r_state == IDLE) begin
            r_idx <= '0;
        end else begin
            r_idx <= r_idx + IW'(1);
        end
    end

    assign event_valid = ~w_fifo_empty;
    assign w_pop       = event_ready & (w_fifo_count != '0);
    assign w_drop      = w_push & w_fifo_full & ~w_pop;

    keypad_event_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (event_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CDIV  = 5;
    localparam int DEB   = 2;
    localparam int DEPTH = 4;
    localparam int N     = ROWS * COLS;
    localparam int IW    = 4;
    localparam int EW    = IW + 1;
    localparam int FRAME = COLS * CDIV;

    logic            clk = 1'b0;
    logic            rst;
    logic [ROWS-1:0] keypad_row;
    logic [COLS-1:0] keypad_col;
    logic [N-1:0]    keypad;
    logic            event_valid;
    logic            event_ready;
    logic [EW-1:0]   event_data;
    logic            overflow;
    logic            overflow_clr;

    logic [N-1:0]    key_down;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .CLK_DIV  (CDIV),
        .DEBOUNCE (DEB),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keypad_row   (keypad_row),
        .keypad_col   (keypad_col),
        .keypad       (keypad),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_data   (event_data),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        keypad_row = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!keypad_col[c] && key_down[c*ROWS+r]) keypad_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int           m_t;
    logic [N-1:0] m_raw, m_prev, m_keypad, m_changed;
    int           m_stable;
    bit           m_fd, m_walk, m_ovf;
    int           m_base;
    logic [EW-1:0] m_q[$];

    always @(posedge clk) begin : model
        int i, c;
        bit have_ev, pop, drop;
        logic [EW-1:0] ev;
        if (!rst) begin
            m_t = 0; m_raw = '0; m_prev = '0; m_keypad = '0; m_changed = '0;
            m_stable = 0; m_fd = 0; m_walk = 0; m_ovf = 0; m_base = 0;
            m_q.delete();
        end else begin
            if (m_fd && m_stable == DEB && m_raw != m_keypad) begin
                m_changed = m_raw ^ m_keypad;
                m_keypad  = m_raw;
                m_walk    = 1;
                m_base    = m_t;
            end
            have_ev = 0;
            ev = '0;
            if (m_walk) begin
                i = m_t - m_base - 1;
                if (i >= 0 && i < N && m_changed[i]) begin
                    have_ev = 1;
                    ev = {m_keypad[i], IW'(i)};
                end
                if (i >= N - 1) m_walk = 0;
            end
            pop = (m_q.size() > 0) && event_ready;
            if (pop) void'(m_q.pop_front());
            drop = 0;
            if (have_ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else drop = 1;
            end
            if (overflow_clr) m_ovf = 0;
            if (drop) m_ovf = 1;
            m_fd = 0;
            if (m_t % CDIV == CDIV - 1) begin
                c = (m_t / CDIV) % COLS;
                for (int r = 0; r < ROWS; r++) m_raw[c*ROWS+r] = key_down[c*ROWS+r];
                if (c == COLS - 1) begin
                    if (m_raw == m_prev) m_stable = (m_stable >= DEB) ? DEB : m_stable + 1;
                    else m_stable = 0;
                    m_prev = m_raw;
                    m_fd = 1;
                end
            end
            m_t++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [COLS-1:0] one;
        logic [COLS-1:0] exp_col;
        if (chk_en) begin
            one = 1;
            exp_col = ~(one << ((m_t / CDIV) % COLS));
            check("keypad_col", keypad_col, exp_col);
            check("keypad", keypad, m_keypad);
            check("event_valid", event_valid, m_q.size() > 0);
            check("overflow", overflow, m_ovf);
            if (m_q.size() > 0) check("event_data", event_data, m_q[0]);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pop_one();
        event_ready = 1'b1;
        wait_cyc(1);
        event_ready = 1'b0;
    endtask

    initial begin
        bit found;
        int hold, rmode;
        rst = 1'b0; key_down = '0; event_ready = 1'b0; overflow_clr = 1'b0;
        wait_cyc(3);
        chk_en = 1'b1;
        check("rst_col", keypad_col, 4'b1110);
        check("rst_keypad", keypad, 0);
        check("rst_valid", event_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", event_data, 0);

        rst = 1'b1;
        wait_cyc(5); check("step_col1", keypad_col, 4'b1101);
        wait_cyc(5); check("step_col2", keypad_col, 4'b1011);
        wait_cyc(5); check("step_col3", keypad_col, 4'b0111);
        wait_cyc(5); check("step_col0", keypad_col, 4'b1110);

        // single press of key 5 (col 1, row 1)
        key_down[5] = 1'b1;
        wait_cyc(6 * FRAME);
        check("single_keypad", keypad, 16'h0020);
        check("single_valid", event_valid, 1);
        check("single_press_ev", event_data, 5'h15);
        pop_one();
        check("single_drained", event_valid, 0);
        key_down = '0;
        wait_cyc(6 * FRAME);
        check("release_keypad", keypad, 0);
        check("release_ev", event_data, 5'h05);
        pop_one();

        // bounce: one-frame press, one-frame gap, one-frame press
        key_down[0] = 1'b1; wait_cyc(FRAME);
        key_down[0] = 1'b0; wait_cyc(FRAME);
        key_down[0] = 1'b1; wait_cyc(FRAME);
        key_down[0] = 1'b0; wait_cyc(6 * FRAME);
        check("bounce_keypad", keypad, 0);
        check("bounce_valid", event_valid, 0);

        // multi-key ordering
        key_down[2] = 1'b1; key_down[15] = 1'b1;
        wait_cyc(6 * FRAME);
        check("multi_keypad", keypad, 16'h8004);
        check("multi_ev0", event_data, 5'h12);
        pop_one();
        check("multi_ev1", event_data, 5'h1F);
        pop_one();
        check("multi_empty", event_valid, 0);
        key_down = '0; event_ready = 1'b1;
        wait_cyc(6 * FRAME);
        event_ready = 1'b0;

        // overflow with backpressure
        key_down[1] = 1'b1; key_down[4] = 1'b1; key_down[7] = 1'b1;
        key_down[9] = 1'b1; key_down[12] = 1'b1;
        wait_cyc(6 * FRAME);
        check("ovf_set", overflow, 1);
        check("ovf_head", event_data, 5'h11);
        overflow_clr = 1'b1; wait_cyc(1); overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        pop_one(); check("ovf_ev1", event_data, 5'h14);
        pop_one(); check("ovf_ev2", event_data, 5'h17);
        pop_one(); check("ovf_ev3", event_data, 5'h19);
        pop_one(); check("ovf_drained", event_valid, 0);
        key_down = '0; event_ready = 1'b1;
        wait_cyc(6 * FRAME);
        event_ready = 1'b0;

        // reset on the cycle after a commit
        key_down[6] = 1'b1;
        found = 0;
        for (int k = 0; k < 10 * FRAME; k++) begin
            wait_cyc(1);
            if (keypad != '0) begin found = 1; break; end
        end
        check("walk_commit_seen", found, 1);
        rst = 1'b0;
        wait_cyc(1);
        check("midwalk_valid", event_valid, 0);
        check("midwalk_keypad", keypad, 0);
        check("midwalk_col", keypad_col, 4'b1110);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(6 * FRAME);
        check("after_rst_keypad", keypad, 16'h0040);
        key_down = '0; event_ready = 1'b1;
        wait_cyc(6 * FRAME);

        // randomized phase
        for (int it = 0; it < 70; it++) begin
            key_down = N'($urandom) & N'($urandom) & N'($urandom);
            hold = $urandom_range(100, 5);
            rmode = $urandom_range(2, 0);
            for (int k = 0; k < hold; k++) begin
                event_ready  = (rmode == 0) ? 1'b0 : ($urandom_range(3, 0) != 0);
                overflow_clr = ($urandom_range(31, 0) == 0);
                wait_cyc(1);
            end
        end
        key_down = '0; event_ready = 1'b1; overflow_clr = 1'b0;
        wait_cyc(10 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
